// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the RAM arbiter slice.
//   state_e     FSM state encoding (2 bits)
//   PORT_CPU    grant index of the CPU core port (port 0)
//   PORT_AUX    grant index of the auxiliary master port (port 1)
//   ADDR_W_DEF  default RAM word-address width (1024 words)
//   DATA_W_DEF  default RAM word width
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the requester handshakes and the RAM-side bus of the
// arbiter.
//   slave  modport: the arbiter (takes requests and ram_data_out, drives acks,
//                   rdata, busy and the registered RAM controls)
//   master modport: the environment (requesters plus the RAM instance)
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester side, held until ack
//   ack0/ack1, rdata0/rdata1                       : completion pulse and read data
//   busy                                           : arbiter is in ISSUE or DONE
//   ram_address, ram_data_in, ram_write_en         : to the RAM
//   ram_data_out                                   : from the RAM (registered in RAM)
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int DATA_WIDTH = DATA_W_DEF
);

   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic                  ram_write_en;
   logic [DATA_WIDTH-1:0] ram_data_out;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
      output ack0, ack1, rdata0, rdata1, busy, ram_address, ram_data_in, ram_write_en
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
      input  ack0, ack1, rdata0, rdata1, busy, ram_address, ram_data_in, ram_write_en
   );

endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select between the two requesters.
// Only meaningful when at least one request is high.
//   req0_i       request from port 0 (CPU)
//   req1_i       request from port 1 (AUX)
//   last_grant_i port that completed the most recent access
//   winner_o     selected port (PORT_CPU / PORT_AUX)
// Build option RAM_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the port
// that did not win last; when undefined, port 0 always wins a tie.
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic winner_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
   always_comb begin
      winner_o = PORT_CPU;
      if (req0_i && req1_i) begin
         winner_o = ~last_grant_i;
      end else if (req1_i) begin
         winner_o = PORT_AUX;
      end
   end
`else
   // last_grant is kept by the top level regardless of build; here it is idle.
   logic last_grant_unused;
   assign last_grant_unused = last_grant_i;

   always_comb begin
      winner_o = PORT_CPU;
      if (!req0_i && req1_i) begin
         winner_o = PORT_AUX;
      end
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU (port 0) and an
// auxiliary master (port 1). Each access takes three clocks: the winner's
// address/data/we are registered toward the RAM, the RAM samples them, and a
// one-cycle ack is returned with the RAM's registered read data.
//   clk    system clock, posedge
//   reset  synchronous, active high
//   bus    ram_arbiter_if.slave (requester handshakes + RAM-side bus)
// Build option RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (see ram_arb_pick); default is fixed priority to port 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting; a request here is latched toward the RAM
// ST_ISSUE | RAM sees the access; it commits/loads at the ending edge
// ST_DONE  | ack pulse to the granted port, read data valid
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int DATA_WIDTH = DATA_W_DEF
)(
   input  logic          clk,
   input  logic          reset,
   ram_arbiter_if.slave  bus
);

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
   logic                  ram_write_en_q, ram_write_en_d;
   logic                  winner;

   ram_arb_pick u_pick (
      .req0_i       (bus.req0),
      .req1_i       (bus.req1),
      .last_grant_i (last_grant_q),
      .winner_o     (winner)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         grant_q        <= PORT_CPU;
         last_grant_q   <= PORT_CPU;
         ram_address_q  <= '0;
         ram_data_in_q  <= '0;
         ram_write_en_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         ram_address_q  <= ram_address_d;
         ram_data_in_q  <= ram_data_in_d;
         ram_write_en_q <= ram_write_en_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      ram_address_d  = ram_address_q;
      ram_data_in_d  = ram_data_in_q;
      ram_write_en_d = ram_write_en_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant_d = winner;
               if (winner == PORT_AUX) begin
                  ram_address_d  = bus.addr1;
                  ram_data_in_d  = bus.wdata1;
                  ram_write_en_d = bus.we1;
               end else begin
                  ram_address_d  = bus.addr0;
                  ram_data_in_d  = bus.wdata0;
                  ram_write_en_d = bus.we0;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // The RAM takes the write at this edge; never hold we for a second cycle.
            ram_write_en_d = 1'b0;
            state_d        = ST_DONE;
         end
         ST_DONE: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: begin
            ram_write_en_d = 1'b0;
            state_d        = ST_IDLE;
         end
      endcase
   end

   assign bus.ack0         = (state_q == ST_DONE) && (grant_q == PORT_CPU);
   assign bus.ack1         = (state_q == ST_DONE) && (grant_q == PORT_AUX);
   assign bus.rdata0       = bus.ram_data_out;
   assign bus.rdata1       = bus.ram_data_out;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.ram_address  = ram_address_q;
   assign bus.ram_data_in  = ram_data_in_q;
   assign bus.ram_write_en = ram_write_en_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 1024x16
// single-port RAM (registered data_out, holds data_out on writes).
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   ram_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) ifc ();

   ram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   logic [15:0] mem [0:1023];
   logic [15:0] ram_q;

   always @(posedge clk) begin
      if (ifc.ram_write_en) mem[ifc.ram_address] <= ifc.ram_data_in;
      else                  ram_q <= mem[ifc.ram_address];
   end
   assign ifc.ram_data_out = ram_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input logic port, input logic we, input logic [9:0] addr,
                          input logic [15:0] wd);
      if (port == PORT_AUX) begin
         ifc.req1 = 1'b1; ifc.we1 = we; ifc.addr1 = addr; ifc.wdata1 = wd;
      end else begin
         ifc.req0 = 1'b1; ifc.we0 = we; ifc.addr0 = addr; ifc.wdata0 = wd;
      end
   endtask

   task automatic clear_req(input logic port);
      if (port == PORT_AUX) ifc.req1 = 1'b0;
      else                  ifc.req0 = 1'b0;
   endtask

   // Drives one access from an IDLE cycle, waits (bounded) for its ack, then
   // drops req and steps into the following IDLE cycle. lat = -1 on timeout.
   task automatic run_access(input logic port, input logic we, input logic [9:0] addr,
                             input logic [15:0] wd, output int lat, output logic [15:0] rd,
                             output int we_cyc, output int other_acks,
                             output logic [9:0] issue_addr);
      lat = -1; rd = '0; we_cyc = 0; other_acks = 0; issue_addr = '0;
      set_req(port, we, addr, wd);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (ifc.ram_write_en) we_cyc++;
         if (i == 1) issue_addr = ifc.ram_address;
         if ((port == PORT_AUX) ? ifc.ack0 : ifc.ack1) other_acks++;
         if ((port == PORT_AUX) ? ifc.ack1 : ifc.ack0) begin
            lat = i;
            rd  = (port == PORT_AUX) ? ifc.rdata1 : ifc.rdata0;
            break;
         end
      end
      clear_req(port);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int          acks_in_reset;
      int          lat, wc, oa;
      logic [15:0] rd;
      logic [9:0]  ia;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ifc.ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ifc.ack0); end
      checks++; if (ifc.ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ifc.ack1); end
      checks++; if (ifc.ram_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ifc.ram_write_en); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
      checks++; if (ifc.ram_address !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", ifc.ram_address); end
      checks++; if (ifc.ram_data_in !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", ifc.ram_data_in); end
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset asserted during ISSUE of a write: the write still lands, no ack.
      set_req(PORT_CPU, 1'b1, 10'h055, 16'h1234);
      @(posedge clk); #1;
      checks++; if (ifc.ram_write_en !== 1'b1) begin errors++; $display("FAIL mid_issue_we: got %b expected 1", ifc.ram_write_en); end
      reset = 1'b1;
      clear_req(PORT_CPU);
      acks_in_reset = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (ifc.ack0 || ifc.ack1) acks_in_reset++;
      end
      reset = 1'b0;
      @(posedge clk); #1;
      if (ifc.ack0 || ifc.ack1) acks_in_reset++;
      checks++; if (acks_in_reset !== 0) begin errors++; $display("FAIL mid_reset_acks: got %0d expected 0", acks_in_reset); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", ifc.busy); end
      checks++; if (ifc.ram_write_en !== 1'b0) begin errors++; $display("FAIL mid_reset_we: got %b expected 0", ifc.ram_write_en); end

      run_access(PORT_CPU, 1'b0, 10'h055, 16'h0000, lat, rd, wc, oa, ia);
      checks++; if (lat !== 2) begin errors++; $display("FAIL mid_reset_read_lat: got %0d expected 2", lat); end
      checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL mid_reset_write_commit: got %h expected 1234", rd); end
   endtask

   task automatic test_write_read_p0();
      int          lat, wc, oa;
      logic [15:0] rd;
      logic [9:0]  ia;
      run_access(PORT_CPU, 1'b1, 10'h012, 16'hA55A, lat, rd, wc, oa, ia);
      checks++; if (lat !== 2) begin errors++; $display("FAIL p0_write_lat: got %0d expected 2", lat); end
      checks++; if (wc !== 1) begin errors++; $display("FAIL p0_write_we_cycles: got %0d expected 1", wc); end
      checks++; if (ia !== 10'h012) begin errors++; $display("FAIL p0_write_addr: got %h expected 012", ia); end
      run_access(PORT_CPU, 1'b0, 10'h012, 16'h0000, lat, rd, wc, oa, ia);
      checks++; if (lat !== 2) begin errors++; $display("FAIL p0_read_lat: got %0d expected 2", lat); end
      checks++; if (wc !== 0) begin errors++; $display("FAIL p0_read_we_cycles: got %0d expected 0", wc); end
      checks++; if (rd !== 16'hA55A) begin errors++; $display("FAIL p0_read_data: got %h expected a55a", rd); end
   endtask

   task automatic test_port1();
      int          lat, wc, oa, oa_total;
      logic [15:0] rd;
      logic [9:0]  ia;
      run_access(PORT_AUX, 1'b1, 10'h3FF, 16'hBEEF, lat, rd, wc, oa, ia);
      oa_total = oa;
      checks++; if (lat !== 2) begin errors++; $display("FAIL p1_write_lat: got %0d expected 2", lat); end
      checks++; if (ia !== 10'h3FF) begin errors++; $display("FAIL p1_write_addr: got %h expected 3ff", ia); end
      run_access(PORT_AUX, 1'b0, 10'h3FF, 16'h0000, lat, rd, wc, oa, ia);
      oa_total += oa;
      checks++; if (lat !== 2) begin errors++; $display("FAIL p1_read_lat: got %0d expected 2", lat); end
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL p1_read_data: got %h expected beef", rd); end
      checks++; if (oa_total !== 0) begin errors++; $display("FAIL p1_ack0_quiet: got %0d ack0 pulses expected 0", oa_total); end
   endtask

   task automatic test_simultaneous();
      int          lat, wc, oa;
      logic [15:0] rd;
      logic [9:0]  ia;
      int          first0, first1, exp0, exp1;
      logic [15:0] rd0, rd1;
      // Port 1 first so the most recent grant is port 0 when the tie arrives.
      run_access(PORT_AUX, 1'b1, 10'h002, 16'h2222, lat, rd, wc, oa, ia);
      run_access(PORT_CPU, 1'b1, 10'h001, 16'h1111, lat, rd, wc, oa, ia);
      first0 = -1; first1 = -1; rd0 = '0; rd1 = '0;
      set_req(PORT_CPU, 1'b0, 10'h001, 16'h0000);
      set_req(PORT_AUX, 1'b0, 10'h002, 16'h0000);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ifc.ack0 && first0 < 0) begin first0 = i; rd0 = ifc.rdata0; clear_req(PORT_CPU); end
         if (ifc.ack1 && first1 < 0) begin first1 = i; rd1 = ifc.rdata1; clear_req(PORT_AUX); end
         if (first0 >= 0 && first1 >= 0) break;
      end
      clear_req(PORT_CPU);
      clear_req(PORT_AUX);
      @(posedge clk); #1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp0 = 5; exp1 = 2;
`else
      exp0 = 2; exp1 = 5;
`endif
      checks++; if (first0 !== exp0) begin errors++; $display("FAIL tie_ack0_cycle: got %0d expected %0d", first0, exp0); end
      checks++; if (first1 !== exp1) begin errors++; $display("FAIL tie_ack1_cycle: got %0d expected %0d", first1, exp1); end
      checks++; if (rd0 !== 16'h1111) begin errors++; $display("FAIL tie_rdata0: got %h expected 1111", rd0); end
      checks++; if (rd1 !== 16'h2222) begin errors++; $display("FAIL tie_rdata1: got %h expected 2222", rd1); end
   endtask

   task automatic test_back_to_back();
      int          n, busy_err, we_err, consec, lat, wc, oa;
      logic        prev_we;
      logic [15:0] rd;
      logic [9:0]  ia;
      n = 0; busy_err = 0; we_err = 0; consec = 0; prev_we = 1'b0;
      set_req(PORT_CPU, 1'b1, 10'h100, 16'h0001);
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         if (ifc.busy !== ((i % 3) != 0)) busy_err++;
         if (ifc.ram_write_en !== ((i % 3) == 1)) we_err++;
         if (ifc.ram_write_en && prev_we) consec++;
         prev_we = ifc.ram_write_en;
         if (ifc.ack0) begin
            n++;
            if (n < 4) set_req(PORT_CPU, 1'b1, 10'h100 + 10'(n), 16'h0001 + 16'(n));
            else       clear_req(PORT_CPU);
         end
      end
      clear_req(PORT_CPU);
      @(posedge clk); #1;
      checks++; if (n !== 4) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 4", n); end
      checks++; if (busy_err !== 0) begin errors++; $display("FAIL b2b_busy_pattern: got %0d bad cycles expected 0", busy_err); end
      checks++; if (we_err !== 0) begin errors++; $display("FAIL b2b_we_pattern: got %0d bad cycles expected 0", we_err); end
      checks++; if (consec !== 0) begin errors++; $display("FAIL b2b_we_consecutive: got %0d expected 0", consec); end
      run_access(PORT_CPU, 1'b0, 10'h100, 16'h0000, lat, rd, wc, oa, ia);
      checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL b2b_read_first: got %h expected 0001", rd); end
      run_access(PORT_CPU, 1'b0, 10'h103, 16'h0000, lat, rd, wc, oa, ia);
      checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL b2b_read_last: got %h expected 0004", rd); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      ifc.req0 = 1'b0; ifc.we0 = 1'b0; ifc.addr0 = '0; ifc.wdata0 = '0;
      ifc.req1 = 1'b0; ifc.we1 = 1'b0; ifc.addr1 = '0; ifc.wdata1 = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      ram_q = 16'h0000;

      test_reset();
      test_write_read_p0();
      test_port1();
      test_simultaneous();
      test_back_to_back();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
